fsm_counter_arbiter: RTL
========================

# fsm_counter_arbiter

Round-robin scheduler that shares a single `fsm_counter_test` run/idle/done counter among `N_REQ` requesters. Each requester posts a level request with its own count value. The arbiter selects one, loads the count into the counter, pulses its run input, waits for its done flag, and returns a one-cycle acknowledge to the owner. It sits between the requesting control blocks and the counter instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `CNT_W`, 7, count width; matches the counter's `i_num_cnt`
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_req`  in  N_REQ  level request per requester; held until its `o_ack` is seen
- `i_num_cnt`  in  N_REQ*CNT_W  packed counts; requester k uses bits [k*CNT_W +: CNT_W]
- `o_grant`  out  N_REQ  one-hot owner of the counter, 0 when free
- `o_ack`  out  N_REQ  one-cycle completion pulse to the owner
- `o_busy`  out  1  high in any state other than IDLE
- `o_cnt_run`  out  1  to counter `is_run`
- `o_cnt_num`  out  CNT_W  to counter `i_num_cnt`
- `i_cnt_idle`  in  1  from counter `o_idle`
- `i_cnt_done`  in  1  from counter `o_done`

## Operation
- States: IDLE, ISSUE, BUSY, DONE.
- Reset behaviour:
  - state goes to IDLE.
  - All outputs go to 0.
  - The last-grant pointer `last` goes to N_REQ-1, so requester 0 has first priority.
- IDLE:
  - Waits for any `i_req` bit high with `i_cnt_idle` = 1.
  - Selection is round-robin: the first set bit searching from `last`+1 mod N_REQ upward.
  - Latch `sel`, set `last` = `sel`, set `o_grant` = 1<<`sel`, set `o_cnt_num` = the count of `sel`.
  - Count nonzero: set `o_cnt_run` = 1 and go to ISSUE.
  - Count zero: skip the counter and go to DONE, with `o_cnt_run` held at 0.
- ISSUE:
  - Lasts exactly one cycle, with `o_cnt_run` = 1.
  - Then `o_cnt_run` = 0 and the state goes to BUSY.
  - `i_cnt_done` is ignored in ISSUE.
- BUSY:
  - Holds `o_grant` and `o_cnt_num`.
  - When `i_cnt_done` = 1, go to DONE and set `o_ack` = `o_grant`.
- DONE:
  - `o_ack` is high for this single cycle.
  - Next edge: `o_grant` = 0, `o_ack` = 0, state goes to IDLE.
- Requester rules:
  - A requester drops `i_req` on the edge where it samples `o_ack` = 1. IDLE then sees the dropped request, so there is no duplicate grant.
  - If `i_req` drops while that requester is granted, the transaction still completes and `o_ack` still pulses.
  - A request dropped before it is granted is simply not serviced.
- `i_req` changes and `i_cnt_done` are ignored in IDLE and DONE.
- The counter count is not changed while it is granted; `o_cnt_num` is stable from ISSUE through DONE.

## Timing
- All outputs are registered.
- From the edge E0 where IDLE samples the request:
  - `o_grant`, `o_cnt_num` and `o_cnt_run` are high during E0..E1.
  - The counter samples `is_run` = 1 at E1.
- From `i_cnt_done` sampled at edge Ed:
  - `o_ack` is high during Ed..Ed+1.
  - The arbiter is back in IDLE at Ed+1.
  - The earliest next grant is at Ed+2.
- Zero count:
  - grant at E0, DONE/`o_ack` during E1..E2, IDLE at E2.
  - `o_cnt_run` is never asserted.
- If `i_cnt_idle` = 0 in IDLE, there is no grant regardless of requests (covers counter reset or a still-running counter).
- Simultaneous requests: exactly one grant per arbitration, chosen by the round-robin order.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs 0 and `last` = N_REQ-1.
  - No `o_ack` is issued for the aborted owner.
  - A counter still running blocks new grants until `i_cnt_idle` returns.
- `o_busy` = (state != IDLE), registered with the state.

## Test plan
- Single request:
  - Stimulus: `i_req`[1] = 1, count 5, counter model idle.
  - Required: `o_grant` = 4'b0010 and `o_cnt_run` for one cycle with `o_cnt_num` = 5.
  - Required: `o_ack`[1] pulses one cycle after `i_cnt_done`, then `o_busy` = 0.
- Simultaneous requests:
  - Stimulus: `i_req`[0] and `i_req`[2] raised together after reset.
  - Required: requester 0 served first, then requester 2; two acks, never both in one cycle.
- Fairness:
  - Stimulus: all four requests held continuously, each re-raised after its ack.
  - Required: grant order 0,1,2,3,0,1; no requester is served twice before the others.
- Zero count:
  - Stimulus: `i_req`[3] with count 0.
  - Required: `o_grant` = 4'b1000 for two cycles, `o_ack`[3] in the second cycle, `o_cnt_run` stays 0.
- Counter not idle:
  - Stimulus: hold `i_cnt_idle` = 0 with `i_req`[0] high for 10 cycles, then release it.
  - Required: no grant during hold; grant on the first edge sampling `i_cnt_idle` = 1.
- Reset in BUSY:
  - Stimulus: assert `reset` for one cycle during BUSY.
  - Required: all outputs 0 next cycle, no `o_ack` emitted, requester 0 has priority again afterward.

Source files
------------

// File: rtl/fsm_counter_arbiter.sv
// Round-robin scheduler sharing one run/idle/done counter among N_REQ requesters.
// Loads the winner's count, pulses run, waits for done and returns a one-cycle ack.
module fsm_counter_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*CNT_W-1:0] i_num_cnt,
    output logic [N_REQ-1:0]       o_grant,
    output logic [N_REQ-1:0]       o_ack,
    output logic                   o_busy,
    output logic                   o_cnt_run,
    output logic [CNT_W-1:0]       o_cnt_num,
    input  logic                   i_cnt_idle,
    input  logic                   i_cnt_done
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   last_q,  last_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q,   ack_d;
    logic               run_q,   run_d;
    logic               busy_q,  busy_d;
    logic [CNT_W-1:0]   num_q,   num_d;

    logic               req_found;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   cand;
    logic [CNT_W-1:0]   sel_cnt;

    // Search upward from the slot after the last owner; the first set bit wins.
    always_comb begin
        req_found = 1'b0;
        sel       = last_q;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = PTR_W'((int'(last_q) + i) % N_REQ);
            if (!req_found && i_req[cand]) begin
                req_found = 1'b1;
                sel       = cand;
            end
        end
    end

    assign sel_cnt = i_num_cnt[int'(sel)*CNT_W +: CNT_W];

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        ack_d   = '0;
        run_d   = 1'b0;
        num_d   = num_q;
        unique case (state_q)
            IDLE: begin
                if (req_found && i_cnt_idle) begin
                    last_d       = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    num_d        = sel_cnt;
                    if (sel_cnt != '0) begin
                        run_d   = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                if (i_cnt_done) begin
                    ack_d   = grant_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                // A zero count arrives here without an ack; raise it first, then release.
                if (ack_q == '0) begin
                    ack_d = grant_q;
                end else begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= PTR_W'(N_REQ - 1);
            grant_q <= '0;
            ack_q   <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            num_q   <= num_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_ack     = ack_q;
    assign o_busy    = busy_q;
    assign o_cnt_run = run_q;
    assign o_cnt_num = num_q;

endmodule
